// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: one 1-bit comparator cell walked MSB-first,
// with its LT/GT/EQ fed back as the next bit's l/g/e seed.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             l_in,
  input  logic             g_in,
  input  logic             e_in,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx_q;
  logic             l_q, g_q, e_q;
  logic             l_d, g_d, e_d;
  logic             ai, bi;
  logic             busy_q, done_q;
  logic             lt_q, gt_q, eq_q;

  assign ai = a_q[idx_q];
  assign bi = b_q[idx_q];

  always_comb begin
    l_d = l_q | (e_q & ~ai & bi);
    g_d = g_q | (e_q & ai & ~bi);
    e_d = e_q & ~(ai ^ bi);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= IW'(WIDTH - 1);
      l_q     <= 1'b0;
      g_q     <= 1'b0;
      e_q     <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            l_q     <= l_in;
            g_q     <= g_in;
            e_q     <= e_in;
            idx_q   <= IW'(WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          l_q   <= l_d;
          g_q   <= g_d;
          e_q   <= e_d;
          idx_q <= idx_q - 1'b1;
          // Fixed WIDTH-edge walk: no early exit keeps latency deterministic.
          if (idx_q == '0) begin
            lt_q    <= l_d;
            gt_q    <= g_d;
            eq_q    <= e_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lt   = lt_q;
  assign gt   = gt_q;
  assign eq   = eq_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed self-checking bench for serial_mag_comparator (WIDTH=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_serial_mag_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in, b_in;
  logic       l_in, g_in, e_in;
  logic       busy, done, lt, gt, eq;

  int nassert = 0;
  int nfail   = 0;
  int nb;
  int cyc;
  int seen;

  serial_mag_comparator #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .l_in  (l_in),
    .g_in  (g_in),
    .e_in  (e_in),
    .busy  (busy),
    .done  (done),
    .lt    (lt),
    .gt    (gt),
    .eq    (eq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic l, g, e);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_lgt"}, {29'd0, lt, gt, eq}, {29'd0, l, g, e});
  endtask

  task automatic launch(input logic [7:0] a, b, input logic l, g, e);
    @(negedge clk);
    a_in = a; b_in = b; l_in = l; g_in = g; e_in = e;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the falling edge where done is seen (or after a bound).
  task automatic wait_done(output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    a_in = '0; b_in = '0; l_in = 1'b0; g_in = 1'b0; e_in = 1'b1;
    #23 rst = 1'b0;
    @(negedge clk);
    chk("rst_out", {27'd0, busy, done, lt, gt, eq}, 32'b00001);
    @(negedge clk);
    chk("idle_out", {27'd0, busy, done, lt, gt, eq}, 32'b00001);

    // Equality: busy exactly 8 cycles, then done
    launch(8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1);
    wait_done(nb);
    chk("eq_busy_cnt", nb, 32'd8);
    chk("eq_busy_low", {31'd0, busy}, 32'd0);
    chk_res("eq", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("eq_done_pulse", {31'd0, done}, 32'd0);
    chk("eq_hold", {29'd0, lt, gt, eq}, 32'b001);

    launch(8'h80, 8'h7F, 1'b0, 1'b0, 1'b1);
    wait_done(nb);
    chk_res("msb", 1'b0, 1'b1, 1'b0);

    launch(8'h10, 8'h11, 1'b0, 1'b0, 1'b1);
    wait_done(nb);
    chk_res("lsb", 1'b1, 1'b0, 1'b0);

    launch(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    wait_done(nb);
    chk_res("seed_g", 1'b0, 1'b1, 1'b0);

    // Inconsistent seed l=1,e=1 passes through; e still lets bit set g
    launch(8'h80, 8'h7F, 1'b1, 1'b0, 1'b1);
    wait_done(nb);
    chk_res("seed_le", 1'b1, 1'b1, 1'b0);

    // start while busy is ignored; operands held
    launch(8'd3, 8'd5, 1'b0, 1'b0, 1'b1);
    @(negedge clk); @(negedge clk);
    a_in = 8'd9; b_in = 8'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(nb);
    chk_res("busy_ign", 1'b1, 1'b0, 1'b0);

    // start during DONE: second done 9 cycles after the first
    a_in = 8'd9; b_in = 8'd1; l_in = 1'b0; g_in = 1'b0; e_in = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin cyc = i; break; end
    end
    chk("b2b_gap", cyc, 32'd9);
    chk_res("b2b", 1'b0, 1'b1, 1'b0);

    // Reset during the 4th SHIFT cycle aborts the operation
    launch(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_out", {27'd0, busy, done, lt, gt, eq}, 32'b00001);
    #3 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("rst_no_done", seen, 32'd0);
    chk("rst_after", {27'd0, busy, done, lt, gt, eq}, 32'b00001);

    launch(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_done(nb);
    chk("post_rst_busy", nb, 32'd8);
    chk_res("post_rst", 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Bit-serial N-bit magnitude comparator built around the 1-bit comparator cell (a, b, l, g, e -> LT, GT, EQ).
- Loads two operands on a start strobe and walks them MSB-first, one bit per clock.
- Each clock it evaluates the cell equations on the current bit pair and feeds the cell's LT/GT/EQ back as the next bit's l/g/e.
- Sits directly upstream of any consumer of a cascaded comparison, replacing a WIDTH-deep combinational cell chain with one cell plus state.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Asynchronous, active-high reset.
- start  input  1  Request to begin a comparison; sampled on the rising edge.
- a_in  input  WIDTH  Operand A, captured when start is accepted.
- b_in  input  WIDTH  Operand B, captured when start is accepted.
- l_in  input  1  Cascade seed "less", captured with the operands.
- g_in  input  1  Cascade seed "greater", captured with the operands.
- e_in  input  1  Cascade seed "equal", captured with the operands.
- busy  output  1  High while a comparison is in progress.
- done  output  1  One-cycle pulse; lt/gt/eq are valid in that cycle.
- lt  output  1  Final LT result; holds until the next result is written.
- gt  output  1  Final GT result; holds until the next result is written.
- eq  output  1  Final EQ result; holds until the next result is written.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, lt=0, gt=0, eq=1, internal l/g/e=0/0/1, bit index=WIDTH-1, operand registers=0.
- Reset is asynchronous and takes effect immediately, including mid-comparison. Any partial result is discarded and done never fires for the aborted operation.
- States: IDLE, SHIFT, DONE.
- IDLE: if start=1 at an edge, capture a_in, b_in and seed l/g/e from l_in/g_in/e_in, set index=WIDTH-1, and go to SHIFT. busy rises in the following cycle.
- SHIFT, each edge: with ai=A[index] and bi=B[index], update
  - l <= l | (e & ~ai & bi)
  - g <= g | (e & ai & ~bi)
  - e <= e & ~(ai ^ bi)
- SHIFT continued: decrement index. The edge that processes index 0 writes the updated l/g/e into lt/gt/eq and moves to DONE.
- No early exit: SHIFT always lasts exactly WIDTH edges, so latency is deterministic.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
  - start=1 during DONE is accepted as if in IDLE, giving back-to-back operation.
  - done is still 1 in that cycle.
- Timing: start sampled at edge k, last bit processed at edge k+WIDTH, done=1 during the cycle after edge k+WIDTH, result visible on that same edge.
- busy=1 exactly in SHIFT. start while busy is ignored; captured operands are unaffected by a_in/b_in changes while busy.
- Inconsistent seeds are passed through literally with no correction. Example: l_in=1 and e_in=1 both asserted.
- With seed e=0, the bits cannot change l or g, so the result equals the seed.
- Combinational outputs: none. All outputs are registered.

Test Plan:
- Reset then idle: rst pulse, no start -> lt=0, gt=0, eq=1, busy=0, done=0; reset released asynchronously mid-cycle has no glitch on outputs.
- Equality: WIDTH=8, a=0x5A, b=0x5A, seed 0/0/1, start one cycle -> busy high 8 cycles, done one cycle later, eq=1, lt=0, gt=0.
- MSB decides: a=0x80, b=0x7F, seed 0/0/1 -> gt=1, lt=0, eq=0. LSB decides: a=0x10, b=0x11 -> lt=1, gt=0, eq=0.
- Seed passthrough: a=0x00, b=0xFF, seed l=0, g=1, e=0 -> gt=1, lt=0, eq=0 regardless of operands.
- Busy protection and back-to-back:
  - Start with a=3, b=5, then pulse start with a=9, b=1 mid-SHIFT -> result lt=1.
  - Start during DONE with a=9, b=1 -> second done exactly 9 cycles after the first, gt=1.
- Reset mid-operation: a=0xFF, b=0x00, assert rst at the 4th SHIFT cycle -> no done, outputs return to 0/0/1, and a new start afterwards completes normally.
